// File: rtl/bram_stream_port.sv
// Valid/ready request front-end for a single-port block RAM with a 2-entry response buffer.
// Optional macro BRAM_STREAM_PORT_WRITE_ACK_EN: writes also return a response (RAM_DO write-through data).
module bram_stream_port #(
  parameter int unsigned ADDR_WIDTH = 1,
  parameter int unsigned DATA_WIDTH = 1
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  REQ_VALID,
  output logic                  REQ_READY,
  input  logic                  REQ_WE,
  input  logic [ADDR_WIDTH-1:0] REQ_ADDR,
  input  logic [DATA_WIDTH-1:0] REQ_DATA,
  output logic                  RESP_VALID,
  input  logic                  RESP_READY,
  output logic [DATA_WIDTH-1:0] RESP_DATA,
  output logic [DATA_WIDTH-1:0] RAM_DI,
  output logic [ADDR_WIDTH-1:0] RAM_ADDR,
  output logic                  RAM_WE,
  input  logic [DATA_WIDTH-1:0] RAM_DO
);

  logic                  pending_q, pending_d;
  logic [1:0]            count_q, count_d;
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] buf_q [2];

  logic accept;
  logic produces_resp;
  logic bypass;
  logic push;
  logic pop_buf;

`ifdef BRAM_STREAM_PORT_WRITE_ACK_EN
  assign produces_resp = 1'b1;
`else
  assign produces_resp = ~REQ_WE;
`endif

  // Ready depends only on registered occupancy so no combinational path from the response side.
  assign REQ_READY = ((count_q + 2'(pending_q)) < 2'd2);
  assign accept    = REQ_VALID & REQ_READY & ~RESET;
  assign RAM_ADDR  = REQ_ADDR;
  assign RAM_DI    = REQ_DATA;
  assign RAM_WE    = accept & REQ_WE;

  // Empty buffer: RAM data bypasses straight to the response port.
  assign bypass     = pending_q & (count_q == 2'd0);
  assign RESP_VALID = pending_q | (count_q != 2'd0);
  assign RESP_DATA  = bypass ? RAM_DO : buf_q[rd_ptr_q];
  assign pop_buf    = (count_q != 2'd0) & RESP_READY;
  assign push       = pending_q & ~(bypass & RESP_READY);

  always_comb begin
    pending_d = accept & produces_resp;
    count_d   = count_q + 2'(push) - 2'(pop_buf);
    wr_ptr_d  = wr_ptr_q ^ push;
    rd_ptr_d  = rd_ptr_q ^ pop_buf;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pending_q <= 1'b0;
      count_q   <= 2'd0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
    end else begin
      pending_q <= pending_d;
      count_q   <= count_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
    end
  end

  // Data storage needs no reset; validity is tracked by count_q.
  always_ff @(posedge CLK) begin
    if (push) buf_q[wr_ptr_q] <= RAM_DO;
  end

endmodule

// File: tb/tb_bram_stream_port.sv
// Self-checking bench for bram_stream_port: queue-based response model plus directed literal checks.
module tb_bram_stream_port;
  localparam int unsigned AW = 4;
  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_we, resp_valid, resp_ready, ram_we;
  logic [AW-1:0] req_addr, ram_addr;
  logic [DW-1:0] req_data, resp_data, ram_di, ram_do;
  logic [DW-1:0] ram [16];

  int tests = 0;
  int fails = 0;
  logic [DW-1:0] q[$];
  logic [DW-1:0] got[$];
  logic [DW-1:0] ref_mem [16];
  bit rand_rr = 1'b0;

  bram_stream_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .CLK(clk), .RESET(rst), .REQ_VALID(req_valid), .REQ_READY(req_ready),
    .REQ_WE(req_we), .REQ_ADDR(req_addr), .REQ_DATA(req_data),
    .RESP_VALID(resp_valid), .RESP_READY(resp_ready), .RESP_DATA(resp_data),
    .RAM_DI(ram_di), .RAM_ADDR(ram_addr), .RAM_WE(ram_we), .RAM_DO(ram_do)
  );

  always #5 clk = ~clk;

  // Write-first single-port RAM with one-cycle read latency.
  always @(posedge clk) begin
    if (ram_we) ram[ram_addr] <= ram_di;
    ram_do <= ram_we ? ram_di : ram[ram_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: every accepted response-producing request queues its expected data; outputs follow the queue.
  initial begin
    logic acc;
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_ram_we", 32'(ram_we), 32'd0);
        q.delete();
      end else begin
        acc = req_valid && (q.size() < 2);
        chk("occupancy_le_2", 32'(q.size() <= 2), 32'd1);
        chk("req_ready", 32'(req_ready), 32'(q.size() < 2));
        chk("resp_valid", 32'(resp_valid), 32'(q.size() > 0));
        chk("ram_we", 32'(ram_we), 32'(acc && req_we));
        if (resp_valid && resp_ready && q.size() > 0) begin
          chk("resp_data", 32'(resp_data), 32'(q[0]));
          got.push_back(resp_data);
          void'(q.pop_front());
        end
        if (acc) begin
          if (req_we) begin
            ref_mem[req_addr] = req_data;
`ifdef BRAM_STREAM_PORT_WRITE_ACK_EN
            q.push_back(req_data);
`endif
          end else begin
            q.push_back(ref_mem[req_addr]);
          end
        end
      end
    end
  end

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
      if (rand_rr) resp_ready = 1'($urandom_range(0, 1));
    end
  endtask

  // Present one request and hold it until accepted; returns the number of stalled cycles.
  task automatic do_req(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d, output int waits);
    logic acc;
    req_valid = 1'b1; req_we = we; req_addr = a; req_data = d;
    waits = 0;
    forever begin
      @(negedge clk);
      acc = req_ready;
      @(posedge clk); #1;
      if (rand_rr) resp_ready = 1'($urandom_range(0, 1));
      if (acc) break;
      waits++;
      if (waits > 100) begin
        chk("req_accept_timeout", 32'd1, 32'd0);
        break;
      end
    end
  endtask

  task automatic drain();
    int n;
    req_valid = 1'b0;
    resp_ready = 1'b1;
    n = 0;
    while (q.size() != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_timeout", 32'(q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int w, wsum, base;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_data = '0; resp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_resp_valid", 32'(resp_valid), 32'd0);
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    chk("reset_ram_we", 32'(ram_we), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Preload value = addr + 1 through the port.
    for (int i = 0; i < 16; i++) do_req(1'b1, AW'(i), DW'(i + 1), w);
    drain();

    // Back-to-back reads 0..7 with the consumer always ready.
    base = got.size(); wsum = 0;
    for (int i = 0; i < 8; i++) begin
      do_req(1'b0, AW'(i), '0, w);
      wsum += w;
    end
    drain();
    chk("burst_stalls", 32'(wsum), 32'd0);
    chk("burst_count", 32'(got.size() - base), 32'd8);
    for (int i = 0; i < 8; i++) chk("burst_data", 32'(got[base + i]), 32'(i + 1));

    // Write 0xA5 to addr 3, then read it back; bypass response one cycle after accept.
    base = got.size();
    do_req(1'b1, 4'd3, 8'hA5, w);
    do_req(1'b0, 4'd3, 8'h00, w);
    req_valid = 1'b0;
    chk("bypass_valid", 32'(resp_valid), 32'd1);
    chk("bypass_data", 32'(resp_data), 32'hA5);
    drain();
`ifdef BRAM_STREAM_PORT_WRITE_ACK_EN
    chk("wr_rd_count", 32'(got.size() - base), 32'd2);
    chk("wr_ack_data", 32'(got[base]), 32'hA5);
    chk("rd_a5_data", 32'(got[base + 1]), 32'hA5);
`else
    chk("wr_rd_count", 32'(got.size() - base), 32'd1);
    chk("rd_a5_data", 32'(got[base]), 32'hA5);
`endif

    // Back-pressure: only two reads accepted while the consumer stalls.
    base = got.size();
    resp_ready = 1'b0;
    do_req(1'b0, 4'd0, '0, w);
    do_req(1'b0, 4'd1, '0, w);
    req_addr = 4'd2;
    repeat (3) begin
      @(posedge clk); #1;
      chk("bp_req_ready_low", 32'(req_ready), 32'd0);
    end
    chk("bp_no_resp", 32'(got.size() - base), 32'd0);
    resp_ready = 1'b1;
    do_req(1'b0, 4'd2, '0, w);
    chk("bp_ready_after_pop", 32'(w), 32'd1);
    drain();
    chk("bp_count", 32'(got.size() - base), 32'd3);
    chk("bp_data0", 32'(got[base]), 32'd1);
    chk("bp_data1", 32'(got[base + 1]), 32'd2);
    chk("bp_data2", 32'(got[base + 2]), 32'd3);

`ifdef BRAM_STREAM_PORT_WRITE_ACK_EN
    base = got.size();
    do_req(1'b1, 4'd5, 8'h3C, w);
    idle(2);
    chk("ack_count", 32'(got.size() - base), 32'd1);
    chk("ack_data", 32'(got[base]), 32'h3C);
    do_req(1'b0, 4'd5, '0, w);
    drain();
    chk("ack_rd_data", 32'(got[base + 1]), 32'h3C);
`else
    base = got.size();
    do_req(1'b1, 4'd5, 8'h3C, w);
    idle(3);
    chk("noack_count", 32'(got.size() - base), 32'd0);
    do_req(1'b0, 4'd5, '0, w);
    drain();
    chk("noack_rd_data", 32'(got[base]), 32'h3C);
`endif

    // Random traffic with random consumer stalls; the model checks every cycle.
    rand_rr = 1'b1;
    for (int i = 0; i < 200; i++) begin
      do_req(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom), w);
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    rand_rr = 1'b0;
    drain();

    // Reset with two reads outstanding discards them.
    resp_ready = 1'b0;
    do_req(1'b0, 4'd4, '0, w);
    do_req(1'b0, 4'd6, '0, w);
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
    chk("midrst_req_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    resp_ready = 1'b1;
    base = got.size();
    idle(5);
    chk("midrst_no_stale", 32'(got.size() - base), 32'd0);
    chk("midrst_valid_after", 32'(resp_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
